// File: rtl/agu_k2_pkg.sv
// agu_k2_pkg: shared state encoding and default widths for the k2 batch scheduler
// Contents: sched_state_e (IDLE, LAUNCH, RUN, DRAIN, DONE), default batch/beat widths,
// and the per-batch beat count for a 2^K2_LOG_N-point k2 transform.
package agu_k2_pkg;
    typedef enum logic [2:0] {IDLE, LAUNCH, RUN, DRAIN, DONE} sched_state_e;
    localparam int BATCH_W_DEF = 8;
    localparam int BEAT_W_DEF = 16;
    localparam int K2_LOG_N = 10;
    localparam int EXP_BEATS_DEF = 1 << K2_LOG_N;
endpackage

// File: rtl/agu_k2_beat_mon.sv
// agu_k2_beat_mon: saturating beat counter, stage capture and sticky beat/protocol error flags
// Ports: clk, rst (sync, active high); clr_cnt zeroes the beat count; cnt_en marks states
// where beats are legal and counted; done_ok marks states where a done pulse is legal;
// chk_en allows the beat-count check on done; clr_err clears both sticky errors;
// beat/done/l_in come from the pipeline; stage_l, err_beats, err_proto are registered outputs.
module agu_k2_beat_mon import agu_k2_pkg::*; #(
    parameter int D_WIDTH = 32,
    parameter int BEAT_W = BEAT_W_DEF,
    parameter int EXP_BEATS = EXP_BEATS_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_cnt,
    input  logic               cnt_en,
    input  logic               done_ok,
    input  logic               chk_en,
    input  logic               clr_err,
    input  logic               beat,
    input  logic               done,
    input  logic [D_WIDTH-1:0] l_in,
    output logic [D_WIDTH-1:0] stage_l,
    output logic               err_beats,
    output logic               err_proto
);
    logic [BEAT_W-1:0] beat_cnt;
    logic [BEAT_W-1:0] cnt_nx;
    logic              bad;
    // a beat coinciding with done is counted before the check
    assign cnt_nx = (cnt_en && beat && !(&beat_cnt)) ? beat_cnt + 1'b1 : beat_cnt;
    assign bad = (done && !done_ok) || (beat && !cnt_en);
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            stage_l <= '0;
            err_beats <= 1'b0;
            err_proto <= 1'b0;
        end else begin
            beat_cnt <= clr_cnt ? '0 : cnt_nx;
            if (beat) stage_l <= l_in;
            err_beats <= !clr_err && (err_beats || (chk_en && done && cnt_nx != BEAT_W'(EXP_BEATS)));
            err_proto <= !clr_err && (err_proto || bad);
        end
    end
endmodule

// File: rtl/agu_k2_sched.sv
// agu_k2_sched: batch scheduler driving the k2 AGU enable with a drain gap between batches
// Ports: clk, rst (sync, active high); cmd_valid/cmd_ready/cmd_batches command handshake;
// abort ends the command; agu_enable_k2 enable level; agu_done_out_k2 done pulse;
// bn_ma_out_en_k2 beat valid; l_agu_out_k2 stage index; busy, batch_idx, stage_l,
// sched_done, err_beats, err_proto status. Optional watchdog under AGU_K2_SCHED_WDOG_EN
// adds parameter WDOG_LIMIT and sticky output err_wdog.
module agu_k2_sched import agu_k2_pkg::*; #(
    parameter int D_WIDTH = 32,
    parameter int BATCH_W = BATCH_W_DEF,
    parameter int BEAT_W = BEAT_W_DEF,
    parameter int EXP_BEATS = EXP_BEATS_DEF,
    parameter int DRAIN_CYC = 4
`ifdef AGU_K2_SCHED_WDOG_EN
    , parameter int WDOG_LIMIT = (1 << 20) - 1
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [BATCH_W-1:0] cmd_batches,
    input  logic               abort,
    output logic               agu_enable_k2,
    input  logic               agu_done_out_k2,
    input  logic               bn_ma_out_en_k2,
    input  logic [D_WIDTH-1:0] l_agu_out_k2,
    output logic               busy,
    output logic [BATCH_W-1:0] batch_idx,
    output logic [D_WIDTH-1:0] stage_l,
    output logic               sched_done,
    output logic               err_beats,
    output logic               err_proto
`ifdef AGU_K2_SCHED_WDOG_EN
    , output logic             err_wdog
`endif
);
    localparam int DR_W = $clog2(DRAIN_CYC + 1);
    sched_state_e       state;
    logic [BATCH_W-1:0] batches;
    logic [DR_W-1:0]    drain_cnt;
    logic               accept;
    logic               last;
    logic               active;
    logic               abort_eff;
    assign accept = cmd_valid && cmd_ready;
    assign last = batch_idx == batches - BATCH_W'(1);
    assign active = state == LAUNCH || state == RUN || state == DRAIN;
`ifdef AGU_K2_SCHED_WDOG_EN
    logic [19:0] wdog;
    logic        wd_hit;
    assign wd_hit = state == RUN && wdog == 20'(WDOG_LIMIT);
    assign abort_eff = abort || wd_hit;
    // held at zero outside RUN, so it starts from zero on every RUN entry
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog <= '0;
            err_wdog <= 1'b0;
        end else begin
            wdog <= (state != RUN || bn_ma_out_en_k2) ? '0 : wdog + 20'd1;
            err_wdog <= !accept && (err_wdog || wd_hit);
        end
    end
`else
    assign abort_eff = abort;
`endif
    // outputs are registered from the next state, so enable is high while in LAUNCH
    // and sched_done is high while in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cmd_ready <= 1'b1;
            agu_enable_k2 <= 1'b0;
            busy <= 1'b0;
            sched_done <= 1'b0;
            batch_idx <= '0;
            batches <= '0;
            drain_cnt <= '0;
        end else begin
            cmd_ready <= state == IDLE && !accept;
            sched_done <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    batches <= cmd_batches;
                    batch_idx <= '0;
                    busy <= 1'b1;
                    state <= cmd_batches == '0 ? DONE : LAUNCH;
                    sched_done <= cmd_batches == '0;
                    agu_enable_k2 <= cmd_batches != '0;
                end
                LAUNCH: state <= RUN;
                RUN: if (agu_done_out_k2) begin
                    agu_enable_k2 <= 1'b0;
                    state <= last ? DONE : DRAIN;
                    sched_done <= last;
                    drain_cnt <= DR_W'(DRAIN_CYC - 1);
                end
                DRAIN: if (drain_cnt == '0) begin
                    batch_idx <= batch_idx + 1'b1;
                    agu_enable_k2 <= 1'b1;
                    state <= LAUNCH;
                end else begin
                    drain_cnt <= drain_cnt - 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            if (active && abort_eff) begin
                state <= DONE;
                agu_enable_k2 <= 1'b0;
                sched_done <= 1'b1;
            end
        end
    end
    agu_k2_beat_mon #(
        .D_WIDTH(D_WIDTH),
        .BEAT_W(BEAT_W),
        .EXP_BEATS(EXP_BEATS)
    ) u_mon (
        .clk(clk),
        .rst(rst),
        .clr_cnt(state == LAUNCH),
        .cnt_en(state == RUN || state == DRAIN),
        .done_ok(state == RUN),
        .chk_en(state == RUN && !abort_eff),
        .clr_err(accept),
        .beat(bn_ma_out_en_k2),
        .done(agu_done_out_k2),
        .l_in(l_agu_out_k2),
        .stage_l(stage_l),
        .err_beats(err_beats),
        .err_proto(err_proto)
    );
endmodule

// File: tb/tb_agu_k2_sched.sv
// tb_agu_k2_sched: directed self-checking bench for agu_k2_sched
module tb_agu_k2_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_batches;
    logic        abort;
    logic        agu_enable_k2;
    logic        agu_done_out_k2;
    logic        bn_ma_out_en_k2;
    logic [31:0] l_agu_out_k2;
    logic        busy;
    logic [7:0]  batch_idx;
    logic [31:0] stage_l;
    logic        sched_done;
    logic        err_beats;
    logic        err_proto;
    int passed = 0;
    int total = 0;
    always #5 clk = ~clk;
    agu_k2_sched dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_batches(cmd_batches),
        .abort(abort),
        .agu_enable_k2(agu_enable_k2),
        .agu_done_out_k2(agu_done_out_k2),
        .bn_ma_out_en_k2(bn_ma_out_en_k2),
        .l_agu_out_k2(l_agu_out_k2),
        .busy(busy),
        .batch_idx(batch_idx),
        .stage_l(stage_l),
        .sched_done(sched_done),
        .err_beats(err_beats),
        .err_proto(err_proto)
    );
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic accept_cmd(input int n);
        cmd_valid = 1'b1;
        cmd_batches = 8'(n);
        step();
        cmd_valid = 1'b0;
    endtask
    // starts in the LAUNCH cycle, ends right after the edge that samples done
    task automatic do_batch(input int b, input int nb);
        total++; if (batch_idx !== 8'(b)) $display("FAIL batch_idx: got %0d want %0d", batch_idx, b); else passed++;
        step();
        for (int i = 0; i < nb; i++) begin
            bn_ma_out_en_k2 = 1'b1;
            l_agu_out_k2 = 32'(b * 100 + i);
            step();
        end
        bn_ma_out_en_k2 = 1'b0;
        agu_done_out_k2 = 1'b1;
        step();
        agu_done_out_k2 = 1'b0;
        total++; if (agu_enable_k2 !== 1'b0) $display("FAIL en_after_done: got %b want 0", agu_enable_k2); else passed++;
        total++; if (stage_l !== 32'(b * 100 + nb - 1)) $display("FAIL stage_l: got %0d want %0d", stage_l, b * 100 + nb - 1); else passed++;
    endtask
    task automatic wait_en();
        int low = 1;
        while (!agu_enable_k2 && low < 40) begin
            step();
            if (!agu_enable_k2) low++;
        end
        total++; if (low !== 4) $display("FAIL drain_gap: got %0d low cycles want 4", low); else passed++;
    endtask
    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        total++; if (cmd_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", cmd_ready); else passed++;
        total++; if ({agu_enable_k2, busy, sched_done, err_beats, err_proto} !== 5'b0) $display("FAIL rst_flags: got %b want 00000", {agu_enable_k2, busy, sched_done, err_beats, err_proto}); else passed++;
        total++; if (batch_idx !== 8'd0 || stage_l !== 32'd0) $display("FAIL rst_regs: got %0d/%0d want 0/0", batch_idx, stage_l); else passed++;
        step();
    endtask
    task automatic test_three_batches();
        accept_cmd(3);
        total++; if (agu_enable_k2 !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b0) $display("FAIL launch: got en=%b busy=%b rdy=%b want 1 1 0", agu_enable_k2, busy, cmd_ready); else passed++;
        for (int b = 0; b < 3; b++) begin
            do_batch(b, 1024);
            if (b < 2) wait_en();
        end
        total++; if (sched_done !== 1'b1 || busy !== 1'b1) $display("FAIL three_done: got done=%b busy=%b want 1 1", sched_done, busy); else passed++;
        step();
        total++; if (sched_done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0) $display("FAIL three_post: got done=%b busy=%b rdy=%b want 0 0 0", sched_done, busy, cmd_ready); else passed++;
        step();
        total++; if (cmd_ready !== 1'b1) $display("FAIL three_ready: got %b want 1", cmd_ready); else passed++;
        total++; if (err_beats !== 1'b0 || err_proto !== 1'b0) $display("FAIL three_err: got %b%b want 00", err_beats, err_proto); else passed++;
    endtask
    task automatic test_zero_batches();
        accept_cmd(0);
        total++; if (sched_done !== 1'b1 || agu_enable_k2 !== 1'b0 || cmd_ready !== 1'b0) $display("FAIL zero_done: got done=%b en=%b rdy=%b want 1 0 0", sched_done, agu_enable_k2, cmd_ready); else passed++;
        step();
        total++; if (sched_done !== 1'b0 || agu_enable_k2 !== 1'b0 || cmd_ready !== 1'b0) $display("FAIL zero_post: got done=%b en=%b rdy=%b want 0 0 0", sched_done, agu_enable_k2, cmd_ready); else passed++;
        step();
        total++; if (cmd_ready !== 1'b1) $display("FAIL zero_ready: got %b want 1", cmd_ready); else passed++;
    endtask
    task automatic test_short_batch();
        accept_cmd(2);
        do_batch(0, 1024);
        total++; if (err_beats !== 1'b0) $display("FAIL short_b0: got %b want 0", err_beats); else passed++;
        wait_en();
        do_batch(1, 1023);
        total++; if (err_beats !== 1'b1 || sched_done !== 1'b1) $display("FAIL short_b1: got err=%b done=%b want 1 1", err_beats, sched_done); else passed++;
        step();
        step();
        total++; if (err_beats !== 1'b1 || cmd_ready !== 1'b1) $display("FAIL short_sticky: got err=%b rdy=%b want 1 1", err_beats, cmd_ready); else passed++;
        accept_cmd(0);
        total++; if (err_beats !== 1'b0) $display("FAIL short_clear: got %b want 0", err_beats); else passed++;
        step();
        step();
    endtask
    task automatic test_abort_done();
        int en_hi = 0;
        int dn_hi = 0;
        accept_cmd(2);
        step();
        for (int i = 0; i < 10; i++) begin
            bn_ma_out_en_k2 = 1'b1;
            step();
        end
        bn_ma_out_en_k2 = 1'b0;
        agu_done_out_k2 = 1'b1;
        abort = 1'b1;
        step();
        agu_done_out_k2 = 1'b0;
        abort = 1'b0;
        total++; if (agu_enable_k2 !== 1'b0 || sched_done !== 1'b1) $display("FAIL abort_edge: got en=%b done=%b want 0 1", agu_enable_k2, sched_done); else passed++;
        total++; if (err_beats !== 1'b0 || err_proto !== 1'b0) $display("FAIL abort_err: got %b%b want 00", err_beats, err_proto); else passed++;
        for (int i = 0; i < 8; i++) begin
            step();
            if (agu_enable_k2) en_hi++;
            if (sched_done) dn_hi++;
        end
        total++; if (en_hi !== 0 || dn_hi !== 0) $display("FAIL abort_after: got en_hi=%0d done_hi=%0d want 0 0", en_hi, dn_hi); else passed++;
        total++; if (batch_idx !== 8'd0 || busy !== 1'b0) $display("FAIL abort_idle: got idx=%0d busy=%b want 0 0", batch_idx, busy); else passed++;
    endtask
    task automatic test_proto_idle();
        agu_done_out_k2 = 1'b1;
        step();
        agu_done_out_k2 = 1'b0;
        total++; if (err_proto !== 1'b1 || busy !== 1'b0) $display("FAIL proto_idle: got err=%b busy=%b want 1 0", err_proto, busy); else passed++;
        accept_cmd(0);
        total++; if (err_proto !== 1'b0) $display("FAIL proto_clear: got %b want 0", err_proto); else passed++;
        step();
        step();
    endtask
    task automatic test_reset_mid_run();
        accept_cmd(1);
        step();
        for (int i = 0; i < 5; i++) begin
            bn_ma_out_en_k2 = 1'b1;
            step();
        end
        bn_ma_out_en_k2 = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (agu_enable_k2 !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL rst_mid: got en=%b busy=%b rdy=%b want 0 0 1", agu_enable_k2, busy, cmd_ready); else passed++;
        accept_cmd(1);
        total++; if (agu_enable_k2 !== 1'b1) $display("FAIL rst_relaunch: got %b want 1", agu_enable_k2); else passed++;
        do_batch(0, 1024);
        total++; if (sched_done !== 1'b1 || err_beats !== 1'b0 || err_proto !== 1'b0) $display("FAIL rst_rerun: got done=%b eb=%b ep=%b want 1 0 0", sched_done, err_beats, err_proto); else passed++;
        step();
        step();
    endtask
    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_batches = '0;
        abort = 1'b0;
        agu_done_out_k2 = 1'b0;
        bn_ma_out_en_k2 = 1'b0;
        l_agu_out_k2 = '0;
        test_reset();
        test_three_batches();
        test_zero_batches();
        test_short_batch();
        test_abort_done();
        test_proto_idle();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
